// File: rtl/uart_pkg.sv
// Shared UART constants and byte type used by the receive-side buffer.
package uart_pkg;

    localparam int UART_DBITS       = 8;
    localparam int UART_FIFO_ADDR_W = 4;

    typedef logic [UART_DBITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
// Kept as its own module so a vendor RAM can be dropped in instead.
module uart_fifo_mem #(
    parameter int DBITS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DBITS-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DBITS-1:0]  rdata
);

    logic [DBITS-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO (first-word-fall-through) behind the UART receiver.
// Optional UART_RX_FIFO_STATS_EN adds a saturating dropped-write counter drop_cnt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS  = UART_DBITS,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBITS-1:0]  wr_data,
    input  logic              rd_en,
    output logic [DBITS-1:0]  rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
`ifdef UART_RX_FIFO_STATS_EN
    output logic [7:0]        drop_cnt,
`endif
    input  logic              ovf_clr
);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic            rd_ok, wr_ok, drop;

    // Flags come only from registered pointers, never from wr_en/rd_en.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        rd_ok = rd_en && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        wr_ok = wr_en && (!full || rd_ok);
        drop  = wr_en && !wr_ok;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'd255)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    uart_fifo_mem #(
        .DBITS  (DBITS),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model plus a negedge monitor.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 2**UART_FIFO_ADDR_W;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      wr_en = 1'b0;
    uart_byte_t                wr_data = '0;
    logic                      rd_en = 1'b0;
    logic                      ovf_clr = 1'b0;
    uart_byte_t                rd_data;
    logic                      empty, full, overflow;
    logic [UART_FIFO_ADDR_W:0] count;
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0]                drop_cnt;
`endif

    uart_rx_fifo #(
        .DBITS  (UART_DBITS),
        .ADDR_W (UART_FIFO_ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
`ifdef UART_RX_FIFO_STATS_EN
        .drop_cnt (drop_cnt),
`endif
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          started  = 1'b0;

    // Reference model: byte queue, sticky flag, saturating drop count
    uart_byte_t  exp_q[$];
    bit          m_ovf = 1'b0;
    int unsigned m_drop = 0;
    bit          m_rd_ok, m_wr_ok, m_dropped;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_rd_ok   = rd_en && (exp_q.size() > 0);
            m_wr_ok   = wr_en && ((exp_q.size() < DEPTH) || m_rd_ok);
            m_dropped = wr_en && !m_wr_ok;
            if (m_rd_ok) void'(exp_q.pop_front());
            if (m_wr_ok) exp_q.push_back(wr_data);
            if (m_dropped)    m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (ovf_clr)                      m_drop = m_dropped ? 1 : 0;
            else if (m_dropped && m_drop < 255) m_drop++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
            check("full", 32'(full), 32'(exp_q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_STATS_EN
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
            if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        ovf_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        int unsigned writes;
        logic        w, r;

        reset = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // Idle after reset, then reads on an empty FIFO
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("empty_read_count", 32'(count), 32'd0);

        // Simultaneous write/read on empty: write wins, count becomes 1
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("wr_rd_empty_count", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        check("first_byte", 32'(rd_data), 32'hA5);
        check("first_empty", 32'(empty), 32'd0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("second_byte", 32'(rd_data), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("drained_empty", 32'(empty), 32'd1);
        check("drained_count", 32'(count), 32'd0);

        // Fill, overflow drop, drain, clear
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'(DEPTH));
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'(DEPTH));
        check("drop_head", 32'(rd_data), 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous read and write reuses the freed slot
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_rw_count", 32'(count), 32'(DEPTH));
        check("full_rw_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("full_rw_last", 32'(rd_data), 32'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Wrap-around with occupancy kept between 0 and 5
        writes = 0;
        for (int i = 0; i < 400 && writes < 40; i++) begin
            w = ($urandom_range(0, 1) == 1) && (exp_q.size() < 5);
            r = ($urandom_range(0, 1) == 1);
            if (w) writes++;
            cyc(w, 8'($urandom), r, 1'b0);
        end
        check("wrap_writes", 32'(writes), 32'd40);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_drained", 32'(empty), 32'd1);

        // Reset with entries stored
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("pre_reset_count", 32'(count), 32'd7);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        check("mid_reset_empty", 32'(empty), 32'd1);
        check("mid_reset_count", 32'(count), 32'd0);

        // Long run of drops, then clear coinciding with another drop
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("many_drops_ovf", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_STATS_EN
        check("drop_cnt_sat", 32'(drop_cnt), 32'd255);
`endif
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        check("clr_and_drop_ovf", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_STATS_EN
        check("clr_and_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Random stress biased towards full so drops and clears interleave
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
